// File: rtl/cg_pkg.sv
// Shared definitions for the cg_link SPI configuration link: register addresses,
// CTRL bit positions, frame lengths and FSM state encoding.
package cg_pkg;

  localparam int unsigned HDR_BITS   = 8;
  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned DATA_BITS  = FRAME_BITS - HDR_BITS;

  typedef enum logic [3:0] {
    ADDR_CTRL   = 4'h0,
    ADDR_LMT    = 4'h1,
    ADDR_DLY    = 4'h2,
    ADDR_STATUS = 4'h3,
    ADDR_ACC    = 4'h4,
    ADDR_ID     = 4'h5
  } cg_addr_e;

  localparam int unsigned CTRL_OE   = 0;
  localparam int unsigned CTRL_EN   = 1;
  localparam int unsigned CTRL_DDS  = 2;
  localparam int unsigned CTRL_LDS  = 3;
  localparam int unsigned CTRL_LEN  = 4;
  localparam int unsigned CTRL_CRST = 7;

  typedef logic [2:0] cg_state_t;
  localparam cg_state_t ST_IDLE = 3'd0;
  localparam cg_state_t ST_HDR  = 3'd1;
  localparam cg_state_t ST_DATA = 3'd2;
  localparam cg_state_t ST_DONE = 3'd3;
  localparam cg_state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/cg_link_sync.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle rise and
// fall pulses derived from the synchronized level.
module cg_link_sync #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] chain_q;
  logic              prev_q;

  // Shift the raw input through the chain; keep one extra flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain_q <= {Stages{RstVal}};
      prev_q  <= RstVal;
    end else begin
      chain_q <= {chain_q[Stages-2:0], d_i};
      prev_q  <= chain_q[Stages-1];
    end
  end

  assign level_o = chain_q[Stages-1];
  assign rise_o  = chain_q[Stages-1] & ~prev_q;
  assign fall_o  = ~chain_q[Stages-1] & prev_q;

endmodule

// File: rtl/cg_link.sv
// SPI mode-0 responder driving cg_core configuration and reading back its status.
// Optional feature macro: CG_LINK_WDOG_EN builds a link watchdog that drops EN/OE
// and sets STATUS.WDT when no frame commits for WDOG_CYCLES clocks.
module cg_link
  import cg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDOG_CYCLES = 1_000_000,
  parameter logic [23:0] ID_VALUE    = 24'hC6_0001
) (
  input  logic        clk,
  input  logic        I_RSTN,
  input  logic        I_SCK,
  input  logic        I_CS_N,
  input  logic        I_MOSI,
  output logic        O_MISO,
  output logic [23:0] O_LMT,
  output logic [23:0] O_DLY,
  output logic        O_OE,
  output logic        O_EN,
  output logic        O_DDS,
  output logic        O_LDS,
  output logic        O_LEN,
  output logic        O_CRST,
  input  logic        I_RTE,
  input  logic [23:0] I_ACC
);

  localparam logic [5:0] HDR_LAST   = 6'(HDR_BITS - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  cg_link_sync #(.Stages(SYNC_STAGES), .RstVal(1'b0)) u_sync_sck (
    .clk_i   (clk),
    .rst_ni  (I_RSTN),
    .d_i     (I_SCK),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // CS_N idles high, so reset its synchronizer high to avoid a false frame start.
  cg_link_sync #(.Stages(SYNC_STAGES), .RstVal(1'b1)) u_sync_cs (
    .clk_i   (clk),
    .rst_ni  (I_RSTN),
    .d_i     (I_CS_N),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  cg_link_sync #(.Stages(SYNC_STAGES), .RstVal(1'b0)) u_sync_mosi (
    .clk_i   (clk),
    .rst_ni  (I_RSTN),
    .d_i     (I_MOSI),
    .level_o (mosi_s),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  cg_state_t   state_q;
  logic [5:0]  bitcnt_q;
  logic [7:0]  hdr_q;
  logic [23:0] shift_q;
  logic [23:0] tx_q;
  logic        miso_q;
  logic        commit_q;
  logic        wr_q;

  logic [4:0]  ctrl_q;
  logic [23:0] lmt_q;
  logic [23:0] dly_q;
  logic        crst_q;
  logic        wdt;

  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic        snap;
  logic        stat_clr;

  // Address completes with the MOSI bit sampled on the 8th rise.
  assign rd_addr  = {hdr_q[2:0], mosi_s};
  assign snap     = sck_rise && !cs_rise && (state_q == ST_HDR) && (bitcnt_q == HDR_LAST);
  assign stat_clr = snap && (rd_addr == ADDR_STATUS);

  // Read-back multiplexer evaluated at the snapshot instant.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_CTRL:   rd_data[4:0] = ctrl_q;
      ADDR_LMT:    rd_data      = lmt_q;
      ADDR_DLY:    rd_data      = dly_q;
      ADDR_STATUS: rd_data[1:0] = {wdt, I_RTE};
      ADDR_ACC:    rd_data      = I_ACC;
      ADDR_ID:     rd_data      = ID_VALUE;
      default:     rd_data      = '0;
    endcase
  end

  // Frame FSM: CS_N rise beats any SCK edge; commit decision is registered for one cycle.
  always_ff @(posedge clk) begin
    if (!I_RSTN) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      hdr_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      commit_q <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      wr_q     <= 1'b0;
      if (cs_rise) begin
        commit_q <= (state_q == ST_DONE);
        wr_q     <= (state_q == ST_DONE) && hdr_q[7];
        state_q  <= ST_IDLE;
        bitcnt_q <= '0;
        miso_q   <= 1'b0;
      end else if (cs_fall) begin
        state_q  <= ST_HDR;
        bitcnt_q <= '0;
        hdr_q    <= '0;
        shift_q  <= '0;
        miso_q   <= 1'b0;
      end else if (sck_rise) begin
        case (state_q)
          ST_HDR: begin
            hdr_q    <= {hdr_q[6:0], mosi_s};
            bitcnt_q <= bitcnt_q + 6'd1;
            if (bitcnt_q == HDR_LAST) begin
              state_q <= ST_DATA;
              tx_q    <= rd_data;
              miso_q  <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q  <= {shift_q[DATA_BITS-2:0], mosi_s};
            bitcnt_q <= bitcnt_q + 6'd1;
            if (bitcnt_q == FRAME_LAST) state_q <= ST_DONE;
          end
          ST_DONE: state_q <= ST_ERR;
          default: ;
        endcase
      end else if (sck_fall && (state_q == ST_DATA)) begin
        miso_q <= tx_q[23];
        tx_q   <= {tx_q[22:0], 1'b0};
      end
    end
  end

`ifdef CG_LINK_WDOG_EN
  logic [31:0] wdog_q;
  logic        wdt_q;
  logic        wdog_expire;

  assign wdog_expire = !commit_q && (wdog_q == 32'd1);
  assign wdt         = wdt_q;
`else
  assign wdt = 1'b0;
`endif

  // Register file: writes land one cycle after the committing CS_N rise.
  always_ff @(posedge clk) begin
    if (!I_RSTN) begin
      ctrl_q <= '0;
      lmt_q  <= '0;
      dly_q  <= '0;
      crst_q <= 1'b0;
    end else begin
      crst_q <= 1'b0;
      if (wr_q) begin
        case (hdr_q[3:0])
          ADDR_CTRL: begin
            ctrl_q <= shift_q[4:0];
            crst_q <= shift_q[CTRL_CRST];
          end
          ADDR_LMT: lmt_q <= shift_q;
          ADDR_DLY: dly_q <= shift_q;
          default: ;
        endcase
      end
`ifdef CG_LINK_WDOG_EN
      if (wdog_expire) begin
        ctrl_q[CTRL_EN] <= 1'b0;
        ctrl_q[CTRL_OE] <= 1'b0;
      end
`endif
    end
  end

`ifdef CG_LINK_WDOG_EN
  // Watchdog reloads on any committed frame and parks at zero once expired.
  always_ff @(posedge clk) begin
    if (!I_RSTN) begin
      wdog_q <= 32'(WDOG_CYCLES);
      wdt_q  <= 1'b0;
    end else begin
      if (commit_q) begin
        wdog_q <= 32'(WDOG_CYCLES);
      end else if (wdog_q != 32'd0) begin
        wdog_q <= wdog_q - 32'd1;
      end
      // A coincident expiry wins over the read-clear so it is never lost.
      if (wdog_expire) begin
        wdt_q <= 1'b1;
      end else if (stat_clr) begin
        wdt_q <= 1'b0;
      end
    end
  end
`endif

  logic unused_sig;
`ifdef CG_LINK_WDOG_EN
  assign unused_sig = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
  assign unused_sig = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall, stat_clr, 32'(WDOG_CYCLES)};
`endif

  assign O_MISO = miso_q & (state_q == ST_DATA);
  assign O_LMT  = lmt_q;
  assign O_DLY  = dly_q;
  assign O_OE   = ctrl_q[CTRL_OE];
  assign O_EN   = ctrl_q[CTRL_EN];
  assign O_DDS  = ctrl_q[CTRL_DDS];
  assign O_LDS  = ctrl_q[CTRL_LDS];
  assign O_LEN  = ctrl_q[CTRL_LEN];
  assign O_CRST = crst_q;

endmodule
